alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 9 +
 rtl/alu.sv | 26 ++
 rtl/alu_arbiter.sv | 69 ++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and arbiter FSM states shared by the alu_arbiter slice
package alu_pkg;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU with equality and illegal-control flags
module alu
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  ctrl,
   output logic [31:0] y,
   output logic        eq,
   output logic        err
);
   assign eq = a == b;
   // Unknown control codes give a zero result and raise err
   always_comb begin
      y   = '0;
      err = 1'b0;
      case (ctrl)
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLT: y = {31'b0, a < b};
         default: err = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters via IDLE/EXEC/RESP FSM
module alu_arbiter
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [63:0] req_op1,
   input  logic [63:0] req_op2,
   input  logic [5:0]  req_ctrl,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_eq,
   output logic        rsp_err,
   output logic        busy,
   output logic        grant_id
);
   state_t      state;
   logic        sel, accept;
   logic [31:0] op1_q, op2_q, alu_y;
   logic [2:0]  ctrl_q;
   logic        alu_eq, alu_err;
   assign sel       = &req_valid ? ~grant_id : req_valid[1];
   assign accept    = state == IDLE && |req_valid;
   assign req_ready = (rst_n && accept) ? 2'b01 << sel : 2'b00;
   assign rsp_valid = state == RESP ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = state != IDLE;
   alu alu_0 (
      .a    (op1_q),
      .b    (op2_q),
      .ctrl (ctrl_q),
      .y    (alu_y),
      .eq   (alu_eq),
      .err  (alu_err)
   );
   // Latch the granted operation, run it for one cycle, then hold the response until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant_id   <= 1'b1;
         op1_q      <= '0;
         op2_q      <= '0;
         ctrl_q     <= '0;
         rsp_result <= '0;
         rsp_eq     <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state    <= EXEC;
               grant_id <= sel;
               op1_q    <= sel ? req_op1[63:32] : req_op1[31:0];
               op2_q    <= sel ? req_op2[63:32] : req_op2[31:0];
               ctrl_q   <= sel ? req_ctrl[5:3] : req_ctrl[2:0];
            end
            EXEC: begin
               state      <= RESP;
               rsp_result <= alu_y;
               rsp_eq     <= alu_eq;
               rsp_err    <= alu_err;
            end
            RESP: if (rsp_ready[grant_id]) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
